// File: rtl/csel_sub_pkg.sv
// Shared types and sizes for the pipelined carry-select subtractor.
// The borrow-flag outputs are built only when SUB_FLAGS_EN is defined.
package csel_sub_pkg;

    localparam int SLICE_W = 4;
    localparam int NIBBLES = 4;
    localparam int DATA_W  = NIBBLES * SLICE_W;
    localparam int LATENCY = NIBBLES;

    typedef logic [SLICE_W-1:0] nibble_t;

    typedef struct packed {
        nibble_t diff;
        logic    borrow;
    } slice_res_t;

endpackage

// File: rtl/sub4_select_slice.sv
// One 4-bit subtractor slice: computes both borrow-in candidates, then picks
// one with the incoming borrow (carry-select, borrow = inverted carry).
module sub4_select_slice
    import csel_sub_pkg::*;
(
    input  nibble_t    a,
    input  nibble_t    b,
    input  logic       borrow_in,
    output slice_res_t res
);

    logic [SLICE_W:0] sum_nb;
    logic [SLICE_W:0] sum_b;
    slice_res_t       cand_nb;
    slice_res_t       cand_b;

    always_comb begin
        // a + ~b + ~borrow_in; the carry out of the top bit is the inverted borrow.
        sum_nb         = {1'b0, a} + {1'b0, ~b} + (SLICE_W+1)'(1);
        sum_b          = {1'b0, a} + {1'b0, ~b};
        cand_nb.diff   = sum_nb[SLICE_W-1:0];
        cand_nb.borrow = ~sum_nb[SLICE_W];
        cand_b.diff    = sum_b[SLICE_W-1:0];
        cand_b.borrow  = ~sum_b[SLICE_W];
        res            = borrow_in ? cand_b : cand_nb;
    end

endmodule

// File: rtl/csel_subtractor16_pipe.sv
// 16-bit D = A - B - Bin, one nibble per pipeline stage with skewed operands.
// Define SUB_FLAGS_EN to add registered zero/neg/ovf outputs aligned with d.
module csel_subtractor16_pipe
    import csel_sub_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] d,
    output logic              bout
`ifdef SUB_FLAGS_EN
    ,
    output logic              zero,
    output logic              neg,
    output logic              ovf
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // One global stall freezes every stage while the result waits; an input
    // transferred at edge N is presented as out_valid for transfer at edge N+4.
    logic stall;

    logic [LATENCY-1:0] valid_q, valid_d;

    logic [DATA_W-SLICE_W-1:0]   a_s0_q, a_s0_d, b_s0_q, b_s0_d;
    logic [DATA_W-2*SLICE_W-1:0] a_s1_q, a_s1_d, b_s1_q, b_s1_d;
    logic [SLICE_W-1:0]          a_s2_q, a_s2_d, b_s2_q, b_s2_d;

    logic [SLICE_W-1:0]   diff_s0_q, diff_s0_d;
    logic [2*SLICE_W-1:0] diff_s1_q, diff_s1_d;
    logic [3*SLICE_W-1:0] diff_s2_q, diff_s2_d;
    logic                 bor_s0_q, bor_s0_d;
    logic                 bor_s1_q, bor_s1_d;
    logic                 bor_s2_q, bor_s2_d;

    logic [DATA_W-1:0] d_q, d_d;
    logic              bout_q, bout_d;
    logic [DATA_W-1:0] full_diff;

    slice_res_t res0, res1, res2, res3;

    sub4_select_slice u_slice0 (
        .a(a[SLICE_W-1:0]), .b(b[SLICE_W-1:0]), .borrow_in(bin), .res(res0)
    );
    sub4_select_slice u_slice1 (
        .a(a_s0_q[SLICE_W-1:0]), .b(b_s0_q[SLICE_W-1:0]), .borrow_in(bor_s0_q), .res(res1)
    );
    sub4_select_slice u_slice2 (
        .a(a_s1_q[SLICE_W-1:0]), .b(b_s1_q[SLICE_W-1:0]), .borrow_in(bor_s1_q), .res(res2)
    );
    sub4_select_slice u_slice3 (
        .a(a_s2_q), .b(b_s2_q), .borrow_in(bor_s2_q), .res(res3)
    );

    assign out_valid = valid_q[LATENCY-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign full_diff = {res3.diff, diff_s2_q};

`ifdef SUB_FLAGS_EN
    logic zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
`endif

    always_comb begin
        valid_d   = valid_q;
        a_s0_d    = a_s0_q;
        b_s0_d    = b_s0_q;
        a_s1_d    = a_s1_q;
        b_s1_d    = b_s1_q;
        a_s2_d    = a_s2_q;
        b_s2_d    = b_s2_q;
        diff_s0_d = diff_s0_q;
        diff_s1_d = diff_s1_q;
        diff_s2_d = diff_s2_q;
        bor_s0_d  = bor_s0_q;
        bor_s1_d  = bor_s1_q;
        bor_s2_d  = bor_s2_q;
        d_d       = d_q;
        bout_d    = bout_q;
`ifdef SUB_FLAGS_EN
        zero_d    = zero_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
`endif
        if (!stall) begin
            valid_d   = {valid_q[LATENCY-2:0], in_valid};
            // Upper operand nibbles ride the skew pipe; finished low nibbles
            // accumulate alongside so the full word lines up at the output.
            a_s0_d    = a[DATA_W-1:SLICE_W];
            b_s0_d    = b[DATA_W-1:SLICE_W];
            diff_s0_d = res0.diff;
            bor_s0_d  = res0.borrow;
            a_s1_d    = a_s0_q[DATA_W-SLICE_W-1:SLICE_W];
            b_s1_d    = b_s0_q[DATA_W-SLICE_W-1:SLICE_W];
            diff_s1_d = {res1.diff, diff_s0_q};
            bor_s1_d  = res1.borrow;
            a_s2_d    = a_s1_q[DATA_W-2*SLICE_W-1:SLICE_W];
            b_s2_d    = b_s1_q[DATA_W-2*SLICE_W-1:SLICE_W];
            diff_s2_d = {res2.diff, diff_s1_q};
            bor_s2_d  = res2.borrow;
            // Output register only loads real results so bubbles leave it alone.
            if (valid_q[LATENCY-2]) begin
                d_d    = full_diff;
                bout_d = res3.borrow;
`ifdef SUB_FLAGS_EN
                zero_d = (full_diff == '0);
                neg_d  = full_diff[DATA_W-1];
                ovf_d  = (a_s2_q[SLICE_W-1] != b_s2_q[SLICE_W-1]) &&
                         (full_diff[DATA_W-1] != a_s2_q[SLICE_W-1]);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        a_s0_q    <= a_s0_d;
        b_s0_q    <= b_s0_d;
        a_s1_q    <= a_s1_d;
        b_s1_q    <= b_s1_d;
        a_s2_q    <= a_s2_d;
        b_s2_q    <= b_s2_d;
        diff_s0_q <= diff_s0_d;
        diff_s1_q <= diff_s1_d;
        diff_s2_q <= diff_s2_d;
        bor_s0_q  <= bor_s0_d;
        bor_s1_q  <= bor_s1_d;
        bor_s2_q  <= bor_s2_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_FLAGS_EN
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
`ifdef SUB_FLAGS_EN
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign d    = d_q;
    assign bout = bout_q;
`ifdef SUB_FLAGS_EN
    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_csel_subtractor16_pipe.sv
// Self-checking bench for csel_subtractor16_pipe against an integer-arithmetic
// reference; flag outputs are checked when SUB_FLAGS_EN is defined.
module tb_csel_subtractor16_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d;
    logic        bout;
    logic [19:0] out_vec;
`ifdef SUB_FLAGS_EN
    logic        zero, neg, ovf;
    assign out_vec = {ovf, neg, zero, bout, d};
`else
    assign out_vec = {3'b000, bout, d};
`endif

    csel_subtractor16_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout)
`ifdef SUB_FLAGS_EN
        , .zero(zero), .neg(neg), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];
    int          obs_cyc[$];

    // Reference: {ovf, neg, zero, bout, d} from plain integer arithmetic.
    function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mbin);
        int          du, ds;
        logic [15:0] md;
        logic        mbout, mz, mn, mo;
        du    = int'(ma) - int'(mb) - int'(mbin);
        ds    = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        md    = du[15:0];
        mbout = (du < 0);
        mz    = (md == 16'h0000);
        mn    = md[15];
        mo    = (ds > 32767) || (ds < -32768);
`ifdef SUB_FLAGS_EN
        return {mo, mn, mz, mbout, md};
`else
        return {3'b000, mbout, md};
`endif
    endfunction

    // Records transfers on both sides; comparisons happen in the test tasks.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                obs_q.push_back(out_vec);
                obs_cyc.push_back(cycle);
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
        end
        cycle++;
    end

    task automatic send(input logic [15:0] sa, input logic [15:0] sb, input logic sbin,
                        output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        a = sa;
        b = sb;
        bin = sbin;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_accept: in_ready never seen after %0d cycles, want 1", waited);
        end
    endtask

    task automatic flush();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k;
        k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (obs_q.size() != n) begin
            errors++;
            $display("FAIL result_count: got %0d want %0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (d !== 16'h0000) begin errors++; $display("FAIL reset_d: got %h want 0000", d); end
        if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b want 0", bout); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef SUB_FLAGS_EN
        checks++;
        if ({zero, neg, ovf} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000", {zero, neg, ovf});
        end
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        int w;
        flush();
        send(16'h1234, 16'h0234, 1'b0, w);
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (out_valid !== (i == 3)) begin
                errors++;
                $display("FAIL single_latency edge+%0d: out_valid got %b want %b", i, out_valid, (i == 3));
            end
        end
        checks += 2;
        if (d !== 16'h1000) begin errors++; $display("FAIL single_d: got %h want 1000", d); end
        if (bout !== 1'b0) begin errors++; $display("FAIL single_bout: got %b want 0", bout); end
`ifdef SUB_FLAGS_EN
        checks++;
        if ({zero, neg, ovf} !== 3'b000) begin
            errors++;
            $display("FAIL single_flags: got %b want 000", {zero, neg, ovf});
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_borrow();
        int w;
        flush();
        send(16'h0000, 16'h0001, 1'b0, w);
        send(16'h8000, 16'h0000, 1'b1, w);
        wait_obs(2, 20);
        if (obs_q.size() == 2) begin
            checks += 2;
            if (obs_q[0][16:0] !== {1'b1, 16'hFFFF}) begin
                errors++;
                $display("FAIL borrow_ripple: got bout/d %h want 1ffff", obs_q[0][16:0]);
            end
            if (obs_q[1][16:0] !== {1'b0, 16'h7FFF}) begin
                errors++;
                $display("FAIL borrow_in_msb: got bout/d %h want 07fff", obs_q[1][16:0]);
            end
`ifdef SUB_FLAGS_EN
            checks += 2;
            if (obs_q[0][19:17] !== 3'b010) begin
                errors++;
                $display("FAIL borrow_flags0: got ovf/neg/zero %b want 010", obs_q[0][19:17]);
            end
            if (obs_q[1][19:17] !== 3'b100) begin
                errors++;
                $display("FAIL borrow_flags1: got ovf/neg/zero %b want 100", obs_q[1][19:17]);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int w;
        flush();
        for (int i = 0; i < 20; i++) begin
            send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)), w);
            checks++;
            if (w != 1) begin
                errors++;
                $display("FAIL b2b_in_ready op %0d: took %0d cycles want 1", i, w);
            end
        end
        wait_obs(20, 40);
        checks++;
        if (exp_q.size() != 20) begin errors++; $display("FAIL b2b_accepted: got %0d want 20", exp_q.size()); end
        if (obs_q.size() == 20 && exp_q.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                checks += 2;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_result %0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
                if (obs_cyc[i] != obs_cyc[0] + i) begin
                    errors++;
                    $display("FAIL b2b_spacing %0d: got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held_d;
        logic        have_held;
        int          stalled;
        held_d = 16'h0000;
        have_held = 1'b0;
        stalled = 0;
        flush();
        fork
            begin
                int w;
                for (int i = 0; i < 6; i++)
                    send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                         1'($urandom_range(0, 1)), w);
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    if (c == 5) out_ready = 1'b0;
                    if (c == 10) out_ready = 1'b1;
                    @(negedge clk);
                    if (out_valid && !out_ready) begin
                        stalled++;
                        checks++;
                        if (in_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL bp_in_ready cycle %0d: got %b want 0", c, in_ready);
                        end
                        if (have_held) begin
                            checks++;
                            if (d !== held_d) begin
                                errors++;
                                $display("FAIL bp_d_hold cycle %0d: got %h want %h", c, d, held_d);
                            end
                        end else begin
                            held_d = d;
                            have_held = 1'b1;
                        end
                    end
                    @(posedge clk);
                    #1;
                end
            end
        join
        checks++;
        if (stalled != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 5", stalled); end
        wait_obs(6, 30);
        checks++;
        if (exp_q.size() != 6) begin errors++; $display("FAIL bp_accepted: got %0d want 6", exp_q.size()); end
        if (obs_q.size() == 6 && exp_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_result %0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        logic pat [6];
        logic ov [12];
        logic want;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
        pat[3] = 1'b0; pat[4] = 1'b0; pat[5] = 1'b1;
        flush();
        a = 16'hFFFF;
        b = 16'hFFFF;
        bin = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 6) ? pat[i] : 1'b0;
            @(negedge clk);
            ov[i] = out_valid;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            want = (i >= 4 && i < 10) ? pat[i-4] : 1'b0;
            checks++;
            if (ov[i] !== want) begin
                errors++;
                $display("FAIL bubble_out_valid slot %0d: got %b want %b", i, ov[i], want);
            end
        end
        wait_obs(3, 10);
        if (obs_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
`ifdef SUB_FLAGS_EN
                if (obs_q[i] !== {3'b010, 1'b1, 16'hFFFF}) begin
                    errors++;
                    $display("FAIL bubble_result %0d: got %h want 5ffff", i, obs_q[i]);
                end
`else
                if (obs_q[i][16:0] !== {1'b1, 16'hFFFF}) begin
                    errors++;
                    $display("FAIL bubble_result %0d: got %h want 1ffff", i, obs_q[i][16:0]);
                end
`endif
            end
        end
    endtask

    task automatic test_reset_midstream();
        int w;
        flush();
        for (int i = 0; i < 3; i++)
            send(16'($urandom_range(1, 65535)), 16'($urandom_range(0, 65535)), 1'b0, w);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        if (d !== 16'h0000) begin errors++; $display("FAIL midrst_d: got %h want 0000", d); end
        if (bout !== 1'b0) begin errors++; $display("FAIL midrst_bout: got %b want 0", bout); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale cycle %0d: out_valid got %b want 0", c, out_valid);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_drained: got %0d results want 0", obs_q.size()); end
    endtask

    initial begin
        in_valid  = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        bin       = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        test_reset();
        test_single();
        test_borrow();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: time %0t reached, want tests complete", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csel_subtractor16_pipe.md
Name: csel_subtractor16_pipe

Overview:
- 16-bit unsigned/two's-complement subtractor computing D = A - B - Bin, the inverse operation of the team's 16-bit carry-select adder.
- Built as a 4-stage pipeline, one 4-bit nibble per stage; each stage computes both borrow-in cases and selects with the borrow registered from the previous stage.
- Valid/ready handshake on input and output; sits between operand registers and the datapath result bus.

Parameters:
- NIBBLES, 4, number of 4-bit stages; fixed at 4, so the data width is 16.
- SLICE_W, 4, bits per stage; fixed.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  16  minuend.
- b  input  16  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- d  output  16  difference.
- bout  output  1  borrow out; 1 when a < b + bin, unsigned.

Behaviour:
- Arithmetic: the nibble result is the low 4 bits of a_n + ~b_n + ~borrow_in; the nibble borrow-out is the inverse of the carry. Stage k uses a[4k+3:4k] and b[4k+3:4k].
- Carry-select: each stage computes a {diff, borrow} pair for borrow_in=0 and for borrow_in=1, then muxes on the borrow from stage k-1. Stage 0 uses bin directly.
- Skew: the operand nibbles for stage k are delayed k cycles in shift registers. Finished nibbles are de-skewed so all 16 bits of d and bout appear together.
- Latency: exactly 4 cycles from an accepted input (in_valid && in_ready at edge N) to out_valid at edge N+4, with no backpressure. Throughput is 1 result per cycle.
- Global stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every pipeline register, including the valid bits, holds.
  - d and bout are stable while out_valid=1 and out_ready=0.
- Valid chain: a 4-bit valid shift register; out_valid is its last bit. Bubbles propagate as valid=0 slots.
- Simultaneous accept and drain: with out_ready=1 and in_valid=1, the output shifts and the new input enters in the same cycle; no data is lost.
- Reset:
  - Asynchronous; clears all valid bits, so out_valid=0.
  - d=0, bout=0.
  - in_ready=1 once rst deasserts (combinational from out_valid=0).
  - Reset mid-operation discards all in-flight data.
- Data registers need no reset except the output stage; valid gating makes them don't-care.
- Wrap-around: 0x0000 - 0x0001 gives d=0xFFFF, bout=1. No saturation.

Optional Feature:
- Macro SUB_FLAGS_EN.
- When defined, adds three output ports, registered and aligned with d and frozen during stall; all reset to 0:
  - zero: 1 when d == 0.
  - neg: d[15].
  - ovf: signed overflow, a[15] != b[15] && d[15] != a[15]. Operand MSBs are carried down the skew pipe to compute it.
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package csel_sub_pkg:
  - localparams DATA_W=16, SLICE_W=4, NIBBLES=4, LATENCY=4.
  - typedef nibble_t (logic [3:0]).
  - typedef slice_res_t {nibble_t diff; logic borrow}.
- Sub-module sub4_select_slice (combinational):
  - inputs: a nibble, b nibble, borrow_in.
  - outputs: slice_res_t for the selected result.
  - internally holds the two precomputed candidates and the mux.
- Top module instantiates it 4 times, plus the skew, de-skew and valid registers.

Test Plan:
- Reset mid-stream with 3 items in flight: assert rst asynchronously between edges → out_valid=0, d=0, bout=0 immediately; no stale output after release.
- Single op a=0x1234, b=0x0234, bin=0, out_ready=1 → out_valid exactly 4 cycles later with d=0x1000, bout=0. With SUB_FLAGS_EN: zero=0, neg=0, ovf=0.
- Borrow ripple across all nibbles: a=0x0000, b=0x0001, bin=0 → d=0xFFFF, bout=1. Then a=0x8000, b=0x0000, bin=1 → d=0x7FFF, bout=0, ovf=1 if enabled.
- Back-to-back: 20 random operand pairs on consecutive cycles, out_ready=1 → 20 results on consecutive cycles, in order, matching the reference model; in_ready stays 1.
- Backpressure: stream 6 ops while holding out_ready=0 from cycle 5 to cycle 9 → in_ready=0 while out_valid=1 and out_ready=0; d holds; all 6 results arrive in order with none dropped or duplicated.
- Bubbles: in_valid pattern 1,0,1,0,0,1 → out_valid shows the same pattern shifted by 4 cycles; a=b=0xFFFF, bin=1 gives d=0xFFFF, bout=1.
